gpu_primitive_assembler: RTL and testbench

GPU_PRIMITIVE_ASSEMBLER -- requirements
Module: gpu_primitive_assembler

---
 rtl/gpu_primitive_assembler_pkg.sv | 32 +++
 rtl/gpu_tri_fifo.sv | 49 ++++
 rtl/gpu_primitive_assembler.sv | 126 ++++++++++++
 tb/tb_gpu_primitive_assembler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_primitive_assembler_pkg.sv
// Shared widths, command bit positions, FSM encoding and triangle payload
// for the primitive assembler.
package gpu_primitive_assembler_pkg;

  localparam int unsigned GSR_WIDTH        = 3;
  localparam int unsigned VERTEX_REG_WIDTH = 16;

  // Command bit positions within the graphics status word
  localparam int unsigned GSR_BEGIN = 0;
  localparam int unsigned GSR_PUSH  = 1;
  localparam int unsigned GSR_END   = 2;

  localparam int unsigned TRI_WIDTH = 3 * VERTEX_REG_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IN_PRIM = 2'd1,
    ST_DRAIN   = 2'd2
  } pa_state_e;

  typedef struct packed {
    logic [VERTEX_REG_WIDTH-1:0] v1;
    logic [VERTEX_REG_WIDTH-1:0] v2;
    logic [VERTEX_REG_WIDTH-1:0] v3;
  } tri_t;

  // A triangle with any two identical vertices has zero area
  function automatic logic is_degenerate(input tri_t t);
    return (t.v1 == t.v2) || (t.v1 == t.v3) || (t.v2 == t.v3);
  endfunction

endpackage

// File: rtl/gpu_tri_fifo.sv
// Triangle buffer: power-of-two depth FIFO with wrap-bit pointers.
module gpu_tri_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointer update; flush empties the buffer without touching storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; a full-and-popping write lands in the slot being vacated
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/gpu_primitive_assembler.sv
// Primitive assembler: decodes BEGIN/PUSH/END from the status word, buffers
// non-degenerate triangles and hands them to the rasteriser.
module gpu_primitive_assembler
  import gpu_primitive_assembler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned STALL_LEVEL = FIFO_DEPTH - 1
) (
  input  logic                        I_CLOCK,
  input  logic                        I_RESET,
  input  logic                        I_LOCK,
  input  logic [GSR_WIDTH-1:0]        I_GSRValue,
  input  logic                        I_GSRValue_Valid,
  input  logic [VERTEX_REG_WIDTH-1:0] I_VertexV1,
  input  logic [VERTEX_REG_WIDTH-1:0] I_VertexV2,
  input  logic [VERTEX_REG_WIDTH-1:0] I_VertexV3,
  input  logic                        I_RastReady,
  output logic                        O_TriValid,
  output logic [VERTEX_REG_WIDTH-1:0] O_TriV1,
  output logic [VERTEX_REG_WIDTH-1:0] O_TriV2,
  output logic [VERTEX_REG_WIDTH-1:0] O_TriV3,
  output logic                        O_GPUStallSignal,
  output logic                        O_PrimDone,
  output logic [15:0]                 O_TriCount,
  output logic [7:0]                  O_DropCount,
  output logic                        O_Overflow
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  pa_state_e        state;
  pa_state_e        state_begin;
  pa_state_e        state_nxt;
  logic             prim_done_nxt;
  logic             cmd_begin;
  logic             cmd_push;
  logic             cmd_end;
  logic             push_ok;
  logic             drop_inc;
  logic             ovf_set;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  tri_t             in_tri;
  tri_t             head_tri;

  assign cmd_begin = I_GSRValue_Valid & I_GSRValue[GSR_BEGIN];
  assign cmd_push  = I_GSRValue_Valid & I_GSRValue[GSR_PUSH];
  assign cmd_end   = I_GSRValue_Valid & I_GSRValue[GSR_END];
  assign in_tri    = tri_t'({I_VertexV1, I_VertexV2, I_VertexV3});

  // Command effects applied in BEGIN, PUSH, END order within one cycle
  always_comb begin
    state_begin   = state;
    state_nxt     = state;
    prim_done_nxt = 1'b0;
    push_ok       = 1'b0;
    drop_inc      = 1'b0;
    ovf_set       = 1'b0;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    if (I_LOCK) begin
      fifo_pop = ~fifo_empty & I_RastReady;
      if (state == ST_IDLE && cmd_begin) state_begin = ST_IN_PRIM;
      push_ok = cmd_push && (state_begin == ST_IN_PRIM);
      if (push_ok) begin
        if (is_degenerate(in_tri))      drop_inc  = 1'b1;
        else if (!fifo_full || fifo_pop) fifo_push = 1'b1;
        else                            ovf_set   = 1'b1;
      end
      state_nxt = state_begin;
      if (state_begin == ST_IN_PRIM && cmd_end) state_nxt = ST_DRAIN;
      // Drain completes once the buffer is empty (no pop can be pending then)
      if (state == ST_DRAIN && fifo_empty) begin
        state_nxt     = ST_IDLE;
        prim_done_nxt = 1'b1;
      end
    end else begin
      state_nxt = ST_IDLE;
    end
  end

  // FSM state, done pulse, counters and sticky overflow
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state       <= ST_IDLE;
      O_PrimDone  <= 1'b0;
      O_TriCount  <= '0;
      O_DropCount <= '0;
      O_Overflow  <= 1'b0;
    end else begin
      state      <= state_nxt;
      O_PrimDone <= prim_done_nxt;
      if (fifo_pop) O_TriCount <= O_TriCount + 16'd1;
      if (drop_inc && O_DropCount != 8'hFF) O_DropCount <= O_DropCount + 8'd1;
      if (!I_LOCK)      O_Overflow <= 1'b0;
      else if (ovf_set) O_Overflow <= 1'b1;
    end
  end

  gpu_tri_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TRI_WIDTH)
  ) u_fifo (
    .clk   (I_CLOCK),
    .rst   (I_RESET),
    .flush (~I_LOCK),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_tri),
    .rdata (head_tri),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head of buffer is presented directly; vertices read as zero when empty
  assign O_TriValid       = ~fifo_empty;
  assign O_TriV1          = fifo_empty ? '0 : head_tri.v1;
  assign O_TriV2          = fifo_empty ? '0 : head_tri.v2;
  assign O_TriV3          = fifo_empty ? '0 : head_tri.v3;
  assign O_GPUStallSignal = (fifo_count >= CNT_W'(STALL_LEVEL)) || (state == ST_DRAIN);

endmodule

// File: tb/tb_gpu_primitive_assembler.sv
// Randomised scoreboard bench for gpu_primitive_assembler.
module tb_gpu_primitive_assembler;
  import gpu_primitive_assembler_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned STALL = DEPTH - 1;
  localparam int          VW    = VERTEX_REG_WIDTH;
  localparam logic [GSR_WIDTH-1:0] C_BEGIN = GSR_WIDTH'(1) << GSR_BEGIN;
  localparam logic [GSR_WIDTH-1:0] C_PUSH  = GSR_WIDTH'(1) << GSR_PUSH;
  localparam logic [GSR_WIDTH-1:0] C_END   = GSR_WIDTH'(1) << GSR_END;
  localparam int PH_IDLE = 0, PH_PRIM = 1, PH_DRAIN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lock = 1'b0;
  logic [GSR_WIDTH-1:0] gsr = '0;
  logic gsr_valid = 1'b0;
  logic [VW-1:0] v1 = '0, v2 = '0, v3 = '0;
  logic ready = 1'b0;
  logic tri_valid, stall, prim_done, overflow;
  logic [VW-1:0] tv1, tv2, tv3;
  logic [15:0] tri_count;
  logic [7:0] drop_count;

  int errors = 0;
  int checks = 0;

  gpu_primitive_assembler dut (
    .I_CLOCK          (clk),
    .I_RESET          (rst),
    .I_LOCK           (lock),
    .I_GSRValue       (gsr),
    .I_GSRValue_Valid (gsr_valid),
    .I_VertexV1       (v1),
    .I_VertexV2       (v2),
    .I_VertexV3       (v3),
    .I_RastReady      (ready),
    .O_TriValid       (tri_valid),
    .O_TriV1          (tv1),
    .O_TriV2          (tv2),
    .O_TriV3          (tv3),
    .O_GPUStallSignal (stall),
    .O_PrimDone       (prim_done),
    .O_TriCount       (tri_count),
    .O_DropCount      (drop_count),
    .O_Overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: primitive phase, buffered-triangle count, counters.
  // exp_q is the scoreboard of accepted triangles in delivery order.
  int          m_phase = PH_IDLE;
  int          m_occ = 0;
  int          m_drop = 0;
  logic [15:0] m_cnt = '0;
  logic        m_done = 1'b0;
  logic        m_ovf = 1'b0;
  logic [3*VW-1:0] exp_q[$];
  logic [3*VW-1:0] got_t;
  logic        mb, mp, me, mpop, mdrain;

  always @(negedge clk) begin
    if (rst) begin
      m_phase = PH_IDLE; m_occ = 0; m_drop = 0; m_cnt = '0;
      m_done = 1'b0; m_ovf = 1'b0; exp_q.delete();
    end else begin
      // Monitor: compare visible state against the model
      chk("tri_valid", 64'(tri_valid), 64'(m_occ != 0));
      chk("stall", 64'(stall), 64'((m_occ >= STALL) || (m_phase == PH_DRAIN)));
      chk("prim_done", 64'(prim_done), 64'(m_done));
      chk("tri_count", 64'(tri_count), 64'(m_cnt));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (tri_valid && ready && lock) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL delivery: got unexpected %0h,%0h,%0h expected nothing", tv1, tv2, tv3);
        end else begin
          got_t = exp_q.pop_front();
          chk("delivery", 64'({tv1, tv2, tv3}), 64'(got_t));
        end
      end
      // Advance model by the effect of the coming rising edge
      if (!lock) begin
        m_phase = PH_IDLE; m_occ = 0; exp_q.delete(); m_ovf = 1'b0; m_done = 1'b0;
      end else begin
        mb = gsr_valid & gsr[GSR_BEGIN];
        mp = gsr_valid & gsr[GSR_PUSH];
        me = gsr_valid & gsr[GSR_END];
        mpop = (m_occ > 0) && ready;
        mdrain = (m_phase == PH_DRAIN) && (m_occ == 0);
        m_done = mdrain;
        if (m_phase == PH_IDLE && mb) m_phase = PH_PRIM;
        if (mp && m_phase == PH_PRIM) begin
          if (v1 == v2 || v1 == v3 || v2 == v3) begin
            if (m_drop < 255) m_drop++;
          end else if (m_occ < DEPTH || mpop) begin
            exp_q.push_back({v1, v2, v3});
            m_occ++;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (m_phase == PH_PRIM && me) m_phase = PH_DRAIN;
        if (mdrain) m_phase = PH_IDLE;
        if (mpop) begin
          m_occ--;
          m_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [GSR_WIDTH-1:0] bits, input logic [VW-1:0] a,
                     input logic [VW-1:0] b, input logic [VW-1:0] c);
    gsr_valid = 1'b1; gsr = bits; v1 = a; v2 = b; v3 = c;
    tick();
    gsr_valid = 1'b0; gsr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_valid", 64'(tri_valid), 64'd0);
    chk("rst_v1", 64'(tv1), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_count", 64'(tri_count), 64'd0);
    rst = 1'b0; lock = 1'b1;

    // Single triangle primitive
    ready = 1'b1;
    cmd(C_BEGIN, 0, 0, 0);
    cmd(C_PUSH, 1, 2, 3);
    chk("t1_valid", 64'(tri_valid), 64'd1);
    chk("t1_v", 64'({tv1, tv2, tv3}), 64'({16'd1, 16'd2, 16'd3}));
    cmd(C_END, 0, 0, 0);
    chk("t1_count", 64'(tri_count), 64'd1);
    repeat (4) tick();
    chk("t1_idle_stall", 64'(stall), 64'd0);

    // Overfill with rasteriser stalled, then drain in order
    ready = 1'b0;
    cmd(C_BEGIN, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cmd(C_PUSH, VW'(10*i+1), VW'(10*i+2), VW'(10*i+3));
      if (i == 2) chk("t2_stall_at3", 64'(stall), 64'd1);
    end
    chk("t2_overflow", 64'(overflow), 64'd1);
    ready = 1'b1;
    repeat (6) tick();
    cmd(C_END, 0, 0, 0);
    repeat (3) tick();
    chk("t2_ovf_sticky", 64'(overflow), 64'd1);
    lock = 1'b0; tick(); lock = 1'b1;
    chk("t2_ovf_flushed", 64'(overflow), 64'd0);

    // Degenerate triangles and drop-counter saturation
    cmd(C_BEGIN, 0, 0, 0);
    cmd(C_PUSH, 7, 7, 9);
    chk("t3_no_valid", 64'(tri_valid), 64'd0);
    chk("t3_drop1", 64'(drop_count), 64'd1);
    for (int i = 0; i < 256; i++) begin
      logic [VW-1:0] a;
      a = VW'($urandom);
      cmd(C_PUSH, a, VW'($urandom), a);
    end
    chk("t3_drop_sat", 64'(drop_count), 64'hFF);
    cmd(C_END, 0, 0, 0);
    repeat (3) tick();

    // Push and pop together while full
    ready = 1'b0;
    cmd(C_BEGIN, 0, 0, 0);
    for (int i = 0; i < 4; i++) cmd(C_PUSH, VW'(100+i), VW'(200+i), VW'(300+i));
    ready = 1'b1;
    cmd(C_PUSH, 555, 666, 777);
    ready = 1'b0;
    chk("t4_no_ovf", 64'(overflow), 64'd0);
    ready = 1'b1;
    repeat (3) tick();
    chk("t4_one_left", 64'(tri_valid), 64'd1);
    cmd(C_END, 0, 0, 0);
    repeat (4) tick();
    cmd(C_BEGIN | C_PUSH | C_END, 4, 5, 6);
    repeat (4) tick();

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      gsr_valid = 1'($urandom_range(0, 1));
      gsr = GSR_WIDTH'($urandom_range(0, 7));
      v1 = VW'($urandom_range(0, 3));
      v2 = VW'($urandom_range(0, 3));
      v3 = VW'($urandom_range(0, 3));
      ready = 1'($urandom_range(0, 1));
      lock = ($urandom_range(0, 39) != 0);
      tick();
    end
    gsr_valid = 1'b0; lock = 1'b1; ready = 1'b1;
    cmd(C_END, 0, 0, 0);
    repeat (8) tick();

    // Asynchronous reset mid-cycle with two triangles buffered
    ready = 1'b0;
    cmd(C_BEGIN, 0, 0, 0);
    cmd(C_PUSH, 11, 12, 13);
    cmd(C_PUSH, 21, 22, 23);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(tri_valid), 64'd0);
    chk("t6_rst_v", 64'({tv1, tv2, tv3}), 64'd0);
    chk("t6_rst_count", 64'(tri_count), 64'd0);
    #2 rst = 1'b0;
    repeat (3) tick();

    // Flush with buffered data keeps the delivered count
    ready = 1'b1;
    cmd(C_BEGIN, 0, 0, 0);
    cmd(C_PUSH, 1, 2, 3);
    cmd(C_PUSH, 4, 5, 6);
    ready = 1'b0;
    cmd(C_PUSH, 7, 8, 9);
    lock = 1'b0; tick(); lock = 1'b1;
    chk("t6_flush_empty", 64'(tri_valid), 64'd0);
    chk("t6_flush_count", 64'(tri_count), 64'd1);
    repeat (2) tick();

    // Delivered-triangle counter wraps after 65536 deliveries
    do_reset();
    ready = 1'b1;
    cmd(C_BEGIN, 0, 0, 0);
    for (int i = 0; i < 65536; i++) cmd(C_PUSH, VW'(i), VW'(i+1), VW'(i+2));
    cmd(C_END, 0, 0, 0);
    repeat (4) tick();
    chk("t7_wrap", 64'(tri_count), 64'd0);
    chk("t7_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
